// File: rtl/procyon_seg7_capture.sv
`default_nettype none
// ============================================================================
// Module   : procyon_seg7_capture
// Purpose  : Reads back a multiplexed seven-segment display bus.
//            - i_seg is active-low; i_dig_sel is one-hot and active-high.
//            - Each digit is debounced, then decoded back to its hex nibble.
//            - When every digit has been captured, the whole frame is handed
//              out on a valid/ready interface.
// Ports    : clk, n_rst      clock, synchronous active-low reset
//            i_seg[6:0]      segments (bit0 top, bits1-5 clockwise, bit6 mid)
//            i_dig_sel[N-1:0] one-hot digit select, bit k = digit k
//            o_value[4N-1:0] captured frame, digit k at [4k+3:4k]
//            o_err[N-1:0]    per-digit illegal-pattern flags
//            o_valid/i_ready frame handshake
//            o_overrun       one-cycle pulse when a completed frame is dropped
//            o_blank[N-1:0]  blank-digit flags (only with the macro below)
// Options  : PROCYON_SEG7_CAPTURE_BLANK_EN - treat 7F (all off) as a legal
//            blank digit and add the o_blank port.
// Revision : 1.0 - initial release
// ============================================================================
module procyon_seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_dig_sel,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic [NUM_DIGITS-1:0]   o_err,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_overrun
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   o_blank
`endif
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  C_STABLE = CW'(STABLE_CYCLES);

    // Sample stage, plus the previous sample for change detection
    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
    logic [NUM_DIGITS-1:0]   errbuf_q, errbuf_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
    logic [NUM_DIGITS-1:0]   blankbuf_q, blankbuf_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
`endif

    logic [3:0] w_nib;
    logic       w_err;
    logic       w_blank;
    logic       w_same;
    logic       w_onehot;
    logic       w_fire;
    logic       w_complete;
    logic       w_load;

    // Segment pattern back to nibble
    always_comb begin
        w_nib   = 4'h0;
        w_err   = 1'b0;
        w_blank = 1'b0;
        case (seg_q)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h18: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
            7'h7F: w_blank = 1'b1;
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_same   = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
        w_onehot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);

        // Saturating dwell counter. Zero means the select is not usable.
        cnt_d = cnt_q;
        if (!w_onehot) begin
            cnt_d = '0;
        end else if (!w_same) begin
            cnt_d = CW'(1);
        end else if (cnt_q != C_STABLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Fire only on the transition into the stable count. A saturated
        // counter that sees a change restarts at 1, which is itself the
        // transition when STABLE_CYCLES is 1.
        w_fire = w_onehot && (cnt_d == C_STABLE) && ((cnt_q != C_STABLE) || !w_same);

        buf_d    = buf_q;
        errbuf_d = errbuf_q;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
        blankbuf_d = blankbuf_q;
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_fire && sel_q[k]) begin
                buf_d[4*k +: 4] = w_nib;
                errbuf_d[k]     = w_err;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
                blankbuf_d[k]   = w_blank;
`endif
            end
        end

        // The frame is judged from the registered mask, so a capture in
        // the same cycle starts the next frame rather than joining this one.
        w_complete = &mask_q;
        w_load     = w_complete && (!valid_q || i_ready);
        overrun_d  = w_complete && valid_q && !i_ready;
        mask_d     = (w_complete ? '0 : mask_q) | (w_fire ? sel_q : '0);

        value_d = value_q;
        err_d   = err_q;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
        blank_d = blank_q;
`endif
        valid_d = valid_q;
        if (w_load) begin
            value_d = buf_q;
            err_d   = errbuf_q;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
            blank_d = blankbuf_q;
`endif
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            seg_q      <= '0;
            seg_prev_q <= '0;
            sel_q      <= '0;
            sel_prev_q <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            buf_q      <= '0;
            errbuf_q   <= '0;
            value_q    <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
            blankbuf_q <= '0;
            blank_q    <= '0;
`endif
        end else begin
            seg_q      <= i_seg;
            seg_prev_q <= seg_q;
            sel_q      <= i_dig_sel;
            sel_prev_q <= sel_q;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            buf_q      <= buf_d;
            errbuf_q   <= errbuf_d;
            value_q    <= value_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
            blankbuf_q <= blankbuf_d;
            blank_q    <= blank_d;
`endif
        end
    end

    assign o_value   = value_q;
    assign o_err     = err_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
    assign o_blank   = blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_procyon_seg7_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_procyon_seg7_capture
// Purpose  : Scoreboard bench for procyon_seg7_capture (4 digits, 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_procyon_seg7_capture;

    localparam int C_N = 4;
    localparam int C_S = 4;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        logic [3:0]  b;
    } frame_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [6:0]  i_seg = 7'h7F;
    logic [3:0]  i_dig_sel = 4'h0;
    logic [15:0] o_value;
    logic [3:0]  o_err;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_overrun;
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
    logic [3:0]  o_blank;
`endif

    procyon_seg7_capture #(.NUM_DIGITS(C_N), .STABLE_CYCLES(C_S)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_seg     (i_seg),
        .i_dig_sel (i_dig_sel),
        .o_value   (o_value),
        .o_err     (o_err),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_overrun (o_overrun)
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
        ,
        .o_blank   (o_blank)
`endif
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     nchk = 0;
    int     nerr = 0;
    int     ovr_cnt = 0;
    int     frames = 0;
    int     last_rise = -1;
    frame_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted frame
    logic        prev_v = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] hold_v;
    logic [3:0]  hold_e;
    always @(negedge clk) begin
        frame_t f;
        if (o_overrun) ovr_cnt++;
        if (o_valid && !prev_v) last_rise = cyc;
        if (n_rst && hold) begin
            chk("hold_value", 32'(o_value), 32'(hold_v));
            chk("hold_err",   32'(o_err),   32'(hold_e));
            chk("hold_valid", 32'(o_valid), 32'd1);
        end
        if (o_valid && i_ready) begin
            frames++;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_frame: got value %h, no frame expected", o_value);
            end else begin
                f = sb.pop_front();
                chk("frame_value", 32'(o_value), 32'(f.v));
                chk("frame_err",   32'(o_err),   32'(f.e));
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
                chk("frame_blank", 32'(o_blank), 32'(f.b));
`endif
            end
        end
        hold   = o_valid && !i_ready;
        hold_v = o_value;
        hold_e = o_err;
        prev_v = o_valid;
    end

    task automatic show_raw(input logic [3:0] sel, input logic [6:0] s, input int n);
        i_dig_sel = sel;
        i_seg     = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] s, input int n);
        show_raw(4'(1 << k), s, n);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
        frame_t f;
        f.v = v;
        f.e = e;
        f.b = b;
        sb.push_back(f);
    endtask

    int c3;

    initial begin
        // Reset with random pins
        n_rst     = 1'b0;
        i_seg     = 7'($urandom);
        i_dig_sel = 4'($urandom);
        @(posedge clk); #1;
        i_seg     = 7'($urandom);
        i_dig_sel = 4'($urandom);
        @(negedge clk);
        chk("rst_valid",   32'(o_valid),   32'd0);
        chk("rst_value",   32'(o_value),   32'd0);
        chk("rst_err",     32'(o_err),     32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        show_raw(4'h0, 7'h7F, 2);

        // Basic frame 1235 and latency from last digit
        push(16'h1235, 4'h0, 4'h0);
        show(0, 7'h12, 6);
        show(1, 7'h30, 6);
        show(2, 7'h24, 6);
        c3 = cyc;
        show(3, 7'h79, 6);
        show_raw(4'h0, 7'h7F, 4);
        chk("latency", 32'(last_rise - c3), 32'(C_S + 2));

        // Debounce: toggling never captures, exact-length hold does,
        // a non-one-hot select never captures
        for (int i = 0; i < 4; i++) show(2, (i % 2 == 0) ? 7'h24 : 7'h30, 2);
        show(2, 7'h0E, 4);
        for (int i = 0; i < 4; i++) show(2, (i % 2 == 0) ? 7'h24 : 7'h30, 2);
        show_raw(4'b0011, 7'h79, 10);
        push(16'hDF00, 4'h0, 4'h0);
        show(0, 7'h40, 6);
        show(1, 7'h40, 6);
        show(3, 7'h21, 6);
        show_raw(4'h0, 7'h7F, 4);

        // Illegal / blank patterns on digits 1 and 2
`ifdef PROCYON_SEG7_CAPTURE_BLANK_EN
        push(16'h0000, 4'b0100, 4'b0010);
`else
        push(16'h0000, 4'b0110, 4'b0000);
`endif
        show(0, 7'h40, 6);
        show(1, 7'h7F, 6);
        show(2, 7'h55, 6);
        show(3, 7'h40, 6);
        show_raw(4'h0, 7'h7F, 4);

        // Backpressure: second frame is dropped with one overrun pulse
        i_ready = 1'b0;
        push(16'hABCD, 4'h0, 4'h0);
        show(0, 7'h21, 6);
        show(1, 7'h46, 6);
        show(2, 7'h03, 6);
        show(3, 7'h08, 6);
        for (int k = 0; k < 4; k++) show(k, 7'h79, 6);
        show_raw(4'h0, 7'h7F, 5);
        chk("overrun_pulses", 32'(ovr_cnt), 32'd1);
        i_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("valid_drop", 32'(o_valid), 32'd0);
        @(posedge clk); #1;

        // Reset mid-frame discards partial capture
        show(0, 7'h40, 6);
        show(1, 7'h40, 6);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        show(2, 7'h40, 6);
        show(3, 7'h40, 6);
        show_raw(4'h0, 7'h7F, 8);
        chk("no_partial_frame", 32'(sb.size()), 32'd0);
        push(16'h0011, 4'h0, 4'h0);
        show(0, 7'h79, 6);
        show(1, 7'h79, 6);
        show_raw(4'h0, 7'h7F, 20);

        chk("sb_empty",      32'(sb.size()), 32'd0);
        chk("frames_total",  32'(frames),    32'd5);
        chk("overrun_total", 32'(ovr_cnt),   32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
